// File: rtl/digicode_sequencer.sv
// digicode_sequencer
//   Front end for the digicode FSM. Accepts keypad events by valid/ready
//   handshake, presents each key to digicode as a one-cycle code, and
//   generates the inter-key timeout pulse. Holds the door strike or siren
//   for a fixed time after digicode reports door/alarm, then clears
//   digicode. Counts consecutive alarms and locks the keypad out once
//   MAX_FAIL is reached.
// Ports
//   clk, reset            clock (rising edge), synchronous active-high reset
//   key_valid/key_code    keypad event in (0-9, A, B, C, P=4'hD)
//   key_ready             key accepted when key_valid && key_ready
//   dc_code               key presented to digicode, 4'hF = no key
//   dc_timeout            one-cycle inter-key timeout pulse to digicode
//   dc_reset              digicode reset (reset or CLEAR state)
//   dc_door, dc_alarm     digicode status
//   door_open, siren      actuator drives
//   locked                keypad lockout active
//   fail_count            consecutive failures so far
module digicode_sequencer #(
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned DOOR_CYCLES    = 500,
  parameter int unsigned ALARM_CYCLES   = 2000,
  parameter int unsigned LOCK_CYCLES    = 10000,
  parameter int unsigned MAX_FAIL       = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic [3:0] dc_code,
  output logic       dc_timeout,
  output logic       dc_reset,
  input  logic       dc_door,
  input  logic       dc_alarm,
  output logic       door_open,
  output logic       siren,
  output logic       locked,
  output logic [2:0] fail_count
);

  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST  = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALARM_LAST = CNT_W'(ALARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [2:0]       FAIL_MAX   = 3'(MAX_FAIL);
  localparam logic [3:0]       NO_KEY     = 4'hF;
  localparam logic [3:0]       KEY_C      = 4'hC;

  // S_TOUT is the cycle dc_timeout is shown to digicode; like S_PRESENT it
  // gives digicode one edge to react before SETTLE samples door/alarm.
  typedef enum logic [3:0] {
    S_CLEAR, S_IDLE, S_PRESENT, S_TOUT, S_SETTLE,
    S_ENTRY, S_OPEN, S_ALARM, S_LOCKOUT
  } state_t;

  state_t           state, next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       fail;
  logic [3:0]       key_q;
  logic             accept;

  assign dc_reset   = reset | (state == S_CLEAR);
  assign fail_count = fail;

  always_comb begin
    accept = key_valid && key_ready;
    next   = state;
    case (state)
      S_CLEAR:   next = (fail == FAIL_MAX) ? S_LOCKOUT : S_IDLE;
      S_IDLE:    if (accept) next = S_PRESENT;
      S_PRESENT: next = S_SETTLE;
      S_TOUT:    next = S_SETTLE;
      S_SETTLE: begin
        if (dc_door)             next = S_OPEN;
        else if (dc_alarm)       next = S_ALARM;
        else if (key_q == KEY_C) next = S_IDLE;
        else                     next = S_ENTRY;
      end
      // an accept in the timeout cycle takes priority over the timeout
      S_ENTRY: begin
        if (accept)              next = S_PRESENT;
        else if (cnt == TO_LAST) next = S_TOUT;
      end
      S_OPEN:    if (cnt == DOOR_LAST)  next = S_CLEAR;
      S_ALARM:   if (cnt == ALARM_LAST) next = S_CLEAR;
      S_LOCKOUT: if (cnt == LOCK_LAST)  next = S_IDLE;
      default:   next = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_CLEAR;
      cnt        <= '0;
      fail       <= '0;
      key_q      <= NO_KEY;
      dc_code    <= NO_KEY;
      dc_timeout <= 1'b0;
      key_ready  <= 1'b0;
      door_open  <= 1'b0;
      siren      <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state <= next;
      if (next != state) cnt <= '0;
      else               cnt <= cnt + 1'b1;

      if (state == S_SETTLE && next == S_OPEN)
        fail <= '0;
      else if (state == S_SETTLE && next == S_ALARM && fail != FAIL_MAX)
        fail <= fail + 3'd1;
      else if (state == S_LOCKOUT && next == S_IDLE)
        fail <= '0;

      // the timeout clears the remembered key so SETTLE never treats it as C
      if (accept)             key_q <= key_code;
      else if (next == S_TOUT) key_q <= NO_KEY;

      // outputs are decoded from the next state so they align with it
      dc_code    <= (next == S_PRESENT) ? key_code : NO_KEY;
      dc_timeout <= (next == S_TOUT);
      key_ready  <= (next == S_IDLE) || (next == S_ENTRY);
      door_open  <= (next == S_OPEN);
      siren      <= (next == S_ALARM);
      locked     <= (next == S_LOCKOUT);
    end
  end

endmodule

// File: tb/tb_digicode_sequencer.sv
module tb_digicode_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'hF;
  logic       key_ready;
  logic [3:0] dc_code;
  logic       dc_timeout;
  logic       dc_reset;
  logic       dc_door = 1'b0;
  logic       dc_alarm = 1'b0;
  logic       door_open;
  logic       siren;
  logic       locked;
  logic [2:0] fail_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  digicode_sequencer #(
    .CNT_W(16), .TIMEOUT_CYCLES(8), .DOOR_CYCLES(4),
    .ALARM_CYCLES(5), .LOCK_CYCLES(6), .MAX_FAIL(2)
  ) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .dc_code(dc_code), .dc_timeout(dc_timeout),
    .dc_reset(dc_reset), .dc_door(dc_door), .dc_alarm(dc_alarm),
    .door_open(door_open), .siren(siren), .locked(locked),
    .fail_count(fail_count)
  );

  // Minimal digicode: secret 2,8,B,0,4; C restarts entry; wrong key or
  // timeout raises alarm; door/alarm held until digicode reset.
  logic [2:0] pos = '0;
  function automatic logic [3:0] secret(input logic [2:0] p);
    case (p)
      3'd0: secret = 4'h2;
      3'd1: secret = 4'h8;
      3'd2: secret = 4'hB;
      3'd3: secret = 4'h0;
      default: secret = 4'h4;
    endcase
  endfunction

  always @(posedge clk) begin
    if (dc_reset) begin
      pos <= '0; dc_door <= 1'b0; dc_alarm <= 1'b0;
    end else if (dc_timeout) begin
      dc_alarm <= 1'b1;
    end else if (dc_code != 4'hF) begin
      if (dc_code == 4'hC) pos <= '0;
      else if (dc_code == secret(pos)) begin
        if (pos == 3'd4) dc_door <= 1'b1;
        pos <= pos + 3'd1;
      end else dc_alarm <= 1'b1;
    end
  end

  typedef struct {
    int unsigned rep;
    logic rst, kv; logic [3:0] kc;
    logic rdy; logic [3:0] code; logic tout, dcr, door, sir, lck; logic [2:0] fail;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(int unsigned rep, logic rst, logic kv, logic [3:0] kc,
                              logic rdy, logic [3:0] code, logic tout, logic dcr,
                              logic door, logic sir, logic lck, logic [2:0] fail);
    vec_t v;
    v.rep = rep; v.rst = rst; v.kv = kv; v.kc = kc; v.rdy = rdy; v.code = code;
    v.tout = tout; v.dcr = dcr; v.door = door; v.sir = sir; v.lck = lck; v.fail = fail;
    tbl.push_back(v);
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send_key(input logic [3:0] k, input string name);
    for (int i = 0; i < 40 && !key_ready; i++) tick();
    chk({name, "_ready"}, key_ready, 1'b1);
    key_valid = 1'b1; key_code = k;
    tick();
    key_valid = 1'b0; key_code = 4'hF;
    chk({name, "_code"}, dc_code, k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic bad;
    int unsigned row;
    // rep rst kv kc | rdy code tout dcr door siren lock fail
    add(1,1,0,4'hF, 0,4'hF,0,1,0,0,0,0);   // reset -> CLEAR
    add(1,0,0,4'hF, 1,4'hF,0,0,0,0,0,0);   // IDLE
    add(1,0,1,4'h2, 0,4'h2,0,0,0,0,0,0);   // door sequence 2,8,B,0,4
    add(1,0,0,4'hF, 0,4'hF,0,0,0,0,0,0);
    add(1,0,0,4'hF, 1,4'hF,0,0,0,0,0,0);
    add(1,0,1,4'h8, 0,4'h8,0,0,0,0,0,0);
    add(1,0,0,4'hF, 0,4'hF,0,0,0,0,0,0);
    add(1,0,0,4'hF, 1,4'hF,0,0,0,0,0,0);
    add(1,0,1,4'hB, 0,4'hB,0,0,0,0,0,0);
    add(1,0,0,4'hF, 0,4'hF,0,0,0,0,0,0);
    add(1,0,0,4'hF, 1,4'hF,0,0,0,0,0,0);
    add(1,0,1,4'h0, 0,4'h0,0,0,0,0,0,0);
    add(1,0,0,4'hF, 0,4'hF,0,0,0,0,0,0);
    add(1,0,0,4'hF, 1,4'hF,0,0,0,0,0,0);
    add(1,0,1,4'h4, 0,4'h4,0,0,0,0,0,0);
    add(1,0,0,4'hF, 0,4'hF,0,0,0,0,0,0);   // SETTLE sees door
    add(4,0,0,4'hF, 0,4'hF,0,0,1,0,0,0);   // OPEN x4
    add(1,0,0,4'hF, 0,4'hF,0,1,0,0,0,0);   // CLEAR
    add(1,0,0,4'hF, 1,4'hF,0,0,0,0,0,0);   // IDLE
    add(1,0,1,4'h2, 0,4'h2,0,0,0,0,0,0);   // keys 2,8 then timeout
    add(1,0,0,4'hF, 0,4'hF,0,0,0,0,0,0);
    add(1,0,0,4'hF, 1,4'hF,0,0,0,0,0,0);
    add(1,0,1,4'h8, 0,4'h8,0,0,0,0,0,0);
    add(1,0,0,4'hF, 0,4'hF,0,0,0,0,0,0);
    add(8,0,0,4'hF, 1,4'hF,0,0,0,0,0,0);   // ENTRY x8
    add(1,0,0,4'hF, 0,4'hF,1,0,0,0,0,0);   // timeout pulse
    add(1,0,0,4'hF, 0,4'hF,0,0,0,0,0,0);   // SETTLE sees alarm
    add(5,0,0,4'hF, 0,4'hF,0,0,0,1,0,1);   // ALARM x5
    add(1,0,0,4'hF, 0,4'hF,0,1,0,0,0,1);
    add(1,0,0,4'hF, 1,4'hF,0,0,0,0,0,1);
    add(1,0,1,4'h5, 0,4'h5,0,0,0,0,0,1);   // wrong key 5, then 7 held
    add(1,0,1,4'h7, 0,4'hF,0,0,0,0,0,1);
    add(5,0,1,4'h7, 0,4'hF,0,0,0,1,0,2);
    add(1,0,1,4'h7, 0,4'hF,0,1,0,0,0,2);
    add(6,0,1,4'h7, 0,4'hF,0,0,0,0,1,2);   // LOCKOUT x6, 7 ignored
    add(1,0,1,4'h7, 1,4'hF,0,0,0,0,0,0);
    add(1,0,1,4'h7, 0,4'h7,0,0,0,0,0,0);   // held 7 finally accepted
    add(1,0,0,4'hF, 0,4'hF,0,0,0,0,0,0);
    add(1,1,0,4'hF, 0,4'hF,0,1,0,0,0,0);   // reset beats pending alarm
    add(1,0,0,4'hF, 1,4'hF,0,0,0,0,0,0);

    row = 0;
    foreach (tbl[i]) begin
      for (int unsigned r = 0; r < tbl[i].rep; r++) begin
        reset = tbl[i].rst; key_valid = tbl[i].kv; key_code = tbl[i].kc;
        tick();
        chk($sformatf("row%0d_ready", row), key_ready,  tbl[i].rdy);
        chk($sformatf("row%0d_code",  row), dc_code,    tbl[i].code);
        chk($sformatf("row%0d_tout",  row), dc_timeout, tbl[i].tout);
        chk($sformatf("row%0d_dcrst", row), dc_reset,   tbl[i].dcr);
        chk($sformatf("row%0d_door",  row), door_open,  tbl[i].door);
        chk($sformatf("row%0d_siren", row), siren,      tbl[i].sir);
        chk($sformatf("row%0d_lock",  row), locked,     tbl[i].lck);
        chk($sformatf("row%0d_fail",  row), fail_count, tbl[i].fail);
        row++;
      end
    end
    reset = 1'b0; key_valid = 1'b0; key_code = 4'hF;

    // keys 2,C return to IDLE and the timeout never fires
    send_key(4'h2, "c_k2");
    tick();
    send_key(4'hC, "c_kc");
    tick();
    tick();
    chk("c_idle_ready", key_ready, 1'b1);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dc_timeout || siren || !key_ready) bad = 1'b1;
    end
    chk("c_quiet", bad, 1'b0);

    // one failure so OPEN entry has a count to clear
    send_key(4'h5, "f_k5");
    for (int i = 0; i < 20 && !siren; i++) tick();
    chk("f_siren", siren, 1'b1);
    chk("f_count", fail_count, 3'd1);

    // accept on the last ENTRY cycle wins over the timeout
    send_key(4'h2, "t_k2");
    tick();
    tick();
    chk("t_entry_ready", key_ready, 1'b1);
    repeat (7) tick();
    chk("t_last_ready", key_ready, 1'b1);
    chk("t_last_tout", dc_timeout, 1'b0);
    key_valid = 1'b1; key_code = 4'h8;
    tick();
    key_valid = 1'b0; key_code = 4'hF;
    chk("t_k8_code", dc_code, 4'h8);
    chk("t_k8_tout", dc_timeout, 1'b0);
    tick();
    chk("t_settle_tout", dc_timeout, 1'b0);
    send_key(4'hB, "t_kb");
    send_key(4'h0, "t_k0");
    send_key(4'h4, "t_k4");
    for (int i = 0; i < 10 && !door_open; i++) tick();
    chk("r_door", door_open, 1'b1);
    chk("r_fail_cleared", fail_count, 3'd0);

    // reset in the middle of OPEN
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("r_door_drop", door_open, 1'b0);
    chk("r_dcreset", dc_reset, 1'b1);
    chk("r_ready_low", key_ready, 1'b0);
    tick();
    chk("r_ready_high", key_ready, 1'b1);
    chk("r_dcreset_low", dc_reset, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
